// File: rtl/headstone_pkg.sv
// Shared constants and types for the headstone sprite controller.
// The optional headstone lifetime feature is enabled with the HEADSTONE_FADE_EN macro.
package headstone_pkg;

    // Default number of headstone slots.
    localparam int HS_SLOTS = 4;

    // Sprite geometry: one ROM word per line, one ROM line per sprite row.
    localparam int SPR_W = 16;
    localparam int SPR_H = 32;

    // Colour used for set sprite pixels.
    localparam logic [11:0] HS_RGB = 12'h888;

    // Width of a slot index for the default slot count.
    localparam int SLOT_IDX_W = (HS_SLOTS > 1) ? $clog2(HS_SLOTS) : 1;

    // Pixel pipeline depth from *_in to *_out.
    localparam int HS_LAT = 2;

    // One headstone slot: valid flag plus the sprite's top-left corner (unclipped).
    typedef struct packed {
        logic        valid;
        logic [10:0] x;
        logic [10:0] y;
    } slot_t;

    // VGA timing bundle carried alongside each pixel.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } timing_t;

    // Number of set bits in an 8-bit vector (slot count is at most 8).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/headstone_slot_match.sv
// Per-slot range compare: decides whether the current pixel falls inside one
// headstone and gives the sprite row/column it maps to. Subtraction wraps, so
// a pixel left of or above the sprite produces a large offset and never hits.
module headstone_slot_match
    import headstone_pkg::*;
(
    input  logic        valid,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    output logic        hit,
    output logic [4:0]  row,
    output logic [3:0]  col
);

    logic [10:0] dx;
    logic [10:0] dy;

    assign dx  = hcount - x;
    assign dy  = vcount - y;
    assign hit = valid & (dx < 11'(SPR_W)) & (dy < 11'(SPR_H));
    assign row = dy[4:0];
    assign col = dx[3:0];

endmodule

// File: rtl/headstone_ctl.sv
// Headstone controller: holds spawned headstones in a shadow table, commits
// them to the drawing table at frame start, and overlays the shared sprite ROM
// onto the pixel stream with a fixed two-cycle latency.
// Build option: define HEADSTONE_FADE_EN to give each headstone a lifetime of
// LIFE_FRAMES frames.
module headstone_ctl
    import headstone_pkg::*;
#(
    parameter int SLOTS       = HS_SLOTS,
    parameter int LIFE_FRAMES = 600
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    input  logic        spawn_valid,
    input  logic [10:0] spawn_x,
    input  logic [10:0] spawn_y,
    output logic        spawn_ready,
    input  logic        clear_all,
    output logic [4:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [3:0]  active_cnt
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    slot_t            shadow_reg  [SLOTS];
    slot_t            active_reg  [SLOTS];
    slot_t            active_next [SLOTS];
    logic [SLOTS-1:0] next_valid;
    logic [SLOTS-1:0] expire;
    logic             vsync_prev_reg;
    logic             commit;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             spawn_fire;
    logic [3:0]       active_cnt_reg;

    // Frame start is the rising edge of vsync_in against its registered copy.
    assign commit = vsync_in & ~vsync_prev_reg;

    // Find the lowest-index free shadow slot.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!shadow_reg[i].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign spawn_ready = free_found & ~clear_all;
    assign spawn_fire  = spawn_valid & spawn_ready;

`ifdef HEADSTONE_FADE_EN
    logic [9:0]       life_reg [SLOTS];
    logic [SLOTS-1:0] fresh_reg;

    // A committed slot whose counter is on its last frame retires at this commit.
    always_comb begin
        expire = '0;
        for (int i = 0; i < SLOTS; i++) begin
            expire[i] = commit & active_reg[i].valid & ~fresh_reg[i] & (life_reg[i] == 10'd1);
        end
    end

    // Lifetime counters: reload for newly spawned slots, count down once per frame.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            fresh_reg <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                life_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (commit) begin
                    if (fresh_reg[i]) begin
                        life_reg[i] <= 10'(LIFE_FRAMES);
                    end else if (active_reg[i].valid && life_reg[i] != 10'd0) begin
                        life_reg[i] <= life_reg[i] - 10'd1;
                    end
                end
                // A spawn in the commit cycle lands after the copy, so it stays pending.
                if (spawn_fire && free_idx == IDX_W'(i)) begin
                    fresh_reg[i] <= 1'b1;
                end else if (commit || clear_all) begin
                    fresh_reg[i] <= 1'b0;
                end
            end
        end
    end
`else
    assign expire = '0;
`endif

    // Shadow table: clear_all beats spawns; expiring slots are freed here too.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                shadow_reg[i] <= '0;
            end
        end else if (clear_all) begin
            for (int i = 0; i < SLOTS; i++) begin
                shadow_reg[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (spawn_fire && free_idx == IDX_W'(i)) begin
                    shadow_reg[i] <= '{valid: 1'b1, x: spawn_x, y: spawn_y};
                end else if (expire[i]) begin
                    shadow_reg[i].valid <= 1'b0;
                end
            end
        end
    end

    // Image of the shadow table as it will appear in the active table after commit.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            active_next[i]       = shadow_reg[i];
            active_next[i].valid = shadow_reg[i].valid & ~expire[i];
            next_valid[i]        = active_next[i].valid;
        end
    end

    // Active table and its population count are refreshed only at frame start.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_reg <= 1'b0;
            active_cnt_reg <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                active_reg[i] <= '0;
            end
        end else begin
            vsync_prev_reg <= vsync_in;
            if (commit) begin
                active_cnt_reg <= popcount8(8'(next_valid));
                for (int i = 0; i < SLOTS; i++) begin
                    active_reg[i] <= active_next[i];
                end
            end
        end
    end

    assign active_cnt = active_cnt_reg;

    // Stage 1: per-slot hit detection.
    logic [SLOTS-1:0] hit_w;
    logic [4:0]       row_w [SLOTS];
    logic [3:0]       col_w [SLOTS];

    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_match
        headstone_slot_match u_match (
            .valid  (active_reg[gi].valid),
            .x      (active_reg[gi].x),
            .y      (active_reg[gi].y),
            .hcount (hcount_in),
            .vcount (vcount_in),
            .hit    (hit_w[gi]),
            .row    (row_w[gi]),
            .col    (col_w[gi])
        );
    end

    logic       win_hit;
    logic [4:0] win_row;
    logic [3:0] win_col;

    // Priority encoder: the lowest-index hitting slot owns the ROM this pixel.
    always_comb begin
        win_hit = 1'b0;
        win_row = '0;
        win_col = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (hit_w[i]) begin
                win_hit = 1'b1;
                win_row = row_w[i];
                win_col = col_w[i];
            end
        end
    end

    assign rom_addr = win_row;

    logic        hit_q;
    logic [3:0]  col_q;
    logic [15:0] rom_data_q;
    logic [11:0] rgb_d1_reg;
    logic [11:0] rgb_out_reg;
    logic        pixel;
    timing_t     tim_reg [HS_LAT];

    // Stage 1 registers: hit, column and the ROM line fetched this cycle.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q      <= 1'b0;
            col_q      <= '0;
            rom_data_q <= '0;
            rgb_d1_reg <= '0;
        end else begin
            hit_q      <= win_hit;
            col_q      <= win_col;
            rom_data_q <= rom_data;
            rgb_d1_reg <= rgb_in;
        end
    end

    // Bit 15 of the ROM word is the leftmost sprite pixel.
    assign pixel = rom_data_q[4'd15 - col_q];

    // Stage 2: overlay the sprite colour unless the pixel is in blanking.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out_reg <= '0;
        end else if (hit_q && pixel && !tim_reg[0].hblnk && !tim_reg[0].vblnk) begin
            rgb_out_reg <= HS_RGB;
        end else begin
            rgb_out_reg <= rgb_d1_reg;
        end
    end

    assign rgb_out = rgb_out_reg;

    // Timing delay line, one stage per pixel pipeline stage.
    for (genvar gi = 0; gi < HS_LAT; gi++) begin : g_tim
        // Shift the timing bundle one stage per clock.
        always_ff @(posedge pclk or negedge rst_n) begin
            if (!rst_n) begin
                tim_reg[gi] <= '0;
            end else if (gi == 0) begin
                tim_reg[gi] <= '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                                 vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};
            end else begin
                tim_reg[gi] <= tim_reg[(gi > 0) ? gi - 1 : 0];
            end
        end
    end

    assign hcount_out = tim_reg[HS_LAT-1].hcount;
    assign vcount_out = tim_reg[HS_LAT-1].vcount;
    assign hsync_out  = tim_reg[HS_LAT-1].hsync;
    assign vsync_out  = tim_reg[HS_LAT-1].vsync;
    assign hblnk_out  = tim_reg[HS_LAT-1].hblnk;
    assign vblnk_out  = tim_reg[HS_LAT-1].vblnk;

endmodule

// File: tb/tb_headstone_ctl.sv
// Directed testbench for headstone_ctl with a small sprite ROM model.
module tb_headstone_ctl;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        spawn_valid;
    logic [10:0] spawn_x, spawn_y;
    logic        spawn_ready;
    logic        clear_all;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data;
    logic [3:0]  active_cnt;

    logic [15:0] rom [32];
    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [11:0] BG = 12'h123;
    localparam logic [11:0] HS = 12'h888;

    assign rom_data = rom[rom_addr];

    always #5 pclk = ~pclk;

    headstone_ctl #(.LIFE_FRAMES(3)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out),
        .spawn_valid(spawn_valid), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_ready(spawn_ready),
        .clear_all(clear_all),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .active_cnt(active_cnt)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Present one pixel and return the composited colour two clocks later.
    task automatic pix(input logic [10:0] h, input logic [10:0] v, input logic blank,
                       output logic [11:0] r);
        hcount_in = h;
        vcount_in = v;
        rgb_in    = BG;
        hblnk_in  = blank;
        tick();
        hblnk_in  = 1'b0;
        tick();
        r = rgb_out;
        $display("pixel (%0d,%0d) blank=%0b -> rgb_out=%h", h, v, blank, r);
    endtask

    task automatic spawn(input logic [10:0] x, input logic [10:0] y);
        spawn_x = x;
        spawn_y = y;
        spawn_valid = 1'b1;
        tick();
        spawn_valid = 1'b0;
        $display("spawn (%0d,%0d)", x, y);
    endtask

    task automatic vsync_pulse();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
        $display("vsync edge, active_cnt=%0d", active_cnt);
    endtask

    task automatic do_clear();
        clear_all = 1'b1;
        tick();
        clear_all = 1'b0;
        vsync_pulse();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hcount_in = 11'd5; vcount_in = 11'd5; rgb_in = 12'hfff;
        hsync_in = 1'b1; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
        spawn_valid = 1'b0; spawn_x = '0; spawn_y = '0; clear_all = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got=%h exp=000", rgb_out); end
        n_checks++; if (hcount_out !== 11'd0) begin n_fail++; $display("FAIL reset_hcount got=%0d exp=0", hcount_out); end
        n_checks++; if (hsync_out !== 1'b0) begin n_fail++; $display("FAIL reset_hsync got=%b exp=0", hsync_out); end
        n_checks++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", active_cnt); end
        n_checks++; if (rom_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        rst_n = 1'b1;
        hsync_in = 1'b0;
        #1;
        n_checks++; if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", spawn_ready); end
        $display("reset released");
    endtask

    task automatic test_latency();
        hcount_in = 11'd0; vcount_in = 11'd0; rgb_in = 12'h000;
        tick(); tick();
        hcount_in = 11'd321; vcount_in = 11'd77; rgb_in = 12'habc;
        hsync_in = 1'b1; vblnk_in = 1'b1;
        tick();
        n_checks++; if (hcount_out !== 11'd0) begin n_fail++; $display("FAIL lat_early got=%0d exp=0", hcount_out); end
        tick();
        $display("latency: hcount_out=%0d vcount_out=%0d rgb_out=%h", hcount_out, vcount_out, rgb_out);
        n_checks++; if (hcount_out !== 11'd321) begin n_fail++; $display("FAIL lat_hcount got=%0d exp=321", hcount_out); end
        n_checks++; if (vcount_out !== 11'd77) begin n_fail++; $display("FAIL lat_vcount got=%0d exp=77", vcount_out); end
        n_checks++; if (hsync_out !== 1'b1 || vblnk_out !== 1'b1) begin n_fail++; $display("FAIL lat_sync got=%b%b exp=11", hsync_out, vblnk_out); end
        n_checks++; if (rgb_out !== 12'habc) begin n_fail++; $display("FAIL lat_rgb got=%h exp=abc", rgb_out); end
        hsync_in = 1'b0; vblnk_in = 1'b0;
        tick(); tick();
    endtask

    task automatic test_basic();
        logic [11:0] r;
        logic [11:0] exp;
        spawn(11'd100, 11'd200);
        vsync_pulse();
        n_checks++; if (active_cnt !== 4'd1) begin n_fail++; $display("FAIL basic_cnt got=%0d exp=1", active_cnt); end
        hcount_in = 11'd105; vcount_in = 11'd205; #1;
        n_checks++; if (rom_addr !== 5'd5) begin n_fail++; $display("FAIL basic_rom_addr got=%0d exp=5", rom_addr); end
        for (int h = 105; h <= 110; h++) begin
            pix(11'(h), 11'd205, 1'b0, r);
            exp = (h >= 106 && h <= 109) ? HS : BG;
            n_checks++; if (r !== exp) begin n_fail++; $display("FAIL basic_pix h=%0d got=%h exp=%h", h, r, exp); end
        end
        pix(11'd107, 11'd205, 1'b1, r);
        n_checks++; if (r !== BG) begin n_fail++; $display("FAIL basic_blank got=%h exp=%h", r, BG); end
    endtask

    task automatic test_full();
        logic [11:0] r;
        do_clear();
        spawn(11'd100, 11'd200);
        spawn(11'd300, 11'd300);
        spawn(11'd400, 11'd300);
        spawn(11'd500, 11'd300);
        n_checks++; if (spawn_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", spawn_ready); end
        spawn_x = 11'd600; spawn_y = 11'd300; spawn_valid = 1'b1;
        tick(); tick(); tick();
        spawn_valid = 1'b0;
        vsync_pulse();
        n_checks++; if (active_cnt !== 4'd4) begin n_fail++; $display("FAIL full_cnt got=%0d exp=4", active_cnt); end
        pix(11'd106, 11'd205, 1'b0, r);
        n_checks++; if (r !== HS) begin n_fail++; $display("FAIL full_draw got=%h exp=%h", r, HS); end
        pix(11'd606, 11'd305, 1'b0, r);
        n_checks++; if (r !== BG) begin n_fail++; $display("FAIL full_fifth got=%h exp=%h", r, BG); end
    endtask

    task automatic test_clear_spawn();
        logic [11:0] r;
        clear_all = 1'b1; spawn_valid = 1'b1; spawn_x = 11'd700; spawn_y = 11'd300;
        #1;
        n_checks++; if (spawn_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready_low got=%b exp=0", spawn_ready); end
        tick();
        clear_all = 1'b0; spawn_valid = 1'b0;
        #1;
        n_checks++; if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready_high got=%b exp=1", spawn_ready); end
        vsync_pulse();
        n_checks++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_cnt got=%0d exp=0", active_cnt); end
        pix(11'd106, 11'd205, 1'b0, r);
        n_checks++; if (r !== BG) begin n_fail++; $display("FAIL clr_old got=%h exp=%h", r, BG); end
        pix(11'd706, 11'd305, 1'b0, r);
        n_checks++; if (r !== BG) begin n_fail++; $display("FAIL clr_new got=%h exp=%h", r, BG); end
    endtask

    task automatic test_midframe();
        logic [11:0] r;
        logic [11:0] exp;
        vcount_in = 11'd10; hcount_in = 11'd40;
        spawn(11'd0, 11'd0);
        pix(11'd3, 11'd6, 1'b0, r);
        n_checks++; if (r !== BG) begin n_fail++; $display("FAIL mid_same_frame got=%h exp=%h", r, BG); end
        vsync_pulse();
        for (int h = 0; h <= 16; h++) begin
            pix(11'(h), 11'd6, 1'b0, r);
            exp = (h < 16) ? HS : BG;
            n_checks++; if (r !== exp) begin n_fail++; $display("FAIL mid_row6 h=%0d got=%h exp=%h", h, r, exp); end
        end
    endtask

    task automatic test_commit_hazard();
        logic [11:0] r;
        do_clear();
        spawn_x = 11'd200; spawn_y = 11'd100; spawn_valid = 1'b1; vsync_in = 1'b1;
        tick();
        spawn_valid = 1'b0; vsync_in = 1'b0;
        tick();
        n_checks++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL hazard_cnt0 got=%0d exp=0", active_cnt); end
        pix(11'd206, 11'd105, 1'b0, r);
        n_checks++; if (r !== BG) begin n_fail++; $display("FAIL hazard_nodraw got=%h exp=%h", r, BG); end
        vsync_pulse();
        n_checks++; if (active_cnt !== 4'd1) begin n_fail++; $display("FAIL hazard_cnt1 got=%0d exp=1", active_cnt); end
        pix(11'd206, 11'd105, 1'b0, r);
        n_checks++; if (r !== HS) begin n_fail++; $display("FAIL hazard_draw got=%h exp=%h", r, HS); end
    endtask

    task automatic test_overlap();
        logic [11:0] r;
        do_clear();
        spawn(11'd50, 11'd50);
        spawn(11'd52, 11'd50);
        vsync_pulse();
        hcount_in = 11'd58; vcount_in = 11'd53; #1;
        n_checks++; if (rom_addr !== 5'd3) begin n_fail++; $display("FAIL ovl_rom_addr got=%0d exp=3", rom_addr); end
        pix(11'd58, 11'd50, 1'b0, r);
        n_checks++; if (r !== HS) begin n_fail++; $display("FAIL ovl_slot0 got=%h exp=%h", r, HS); end
        pix(11'd60, 11'd50, 1'b0, r);
        n_checks++; if (r !== BG) begin n_fail++; $display("FAIL ovl_priority got=%h exp=%h", r, BG); end
    endtask

    task automatic test_lifetime();
        logic [11:0] r;
        logic [11:0] exp;
        logic [3:0]  exp_cnt;
        do_clear();
        spawn(11'd300, 11'd400);
        for (int f = 1; f <= 4; f++) begin
            vsync_pulse();
`ifdef HEADSTONE_FADE_EN
            exp = (f <= 3) ? HS : BG;
            exp_cnt = (f <= 3) ? 4'd1 : 4'd0;
`else
            exp = HS;
            exp_cnt = 4'd1;
`endif
            pix(11'd306, 11'd405, 1'b0, r);
            n_checks++; if (r !== exp) begin n_fail++; $display("FAIL life_draw frame=%0d got=%h exp=%h", f, r, exp); end
            n_checks++; if (active_cnt !== exp_cnt) begin n_fail++; $display("FAIL life_cnt frame=%0d got=%0d exp=%0d", f, active_cnt, exp_cnt); end
            n_checks++; if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL life_ready frame=%0d got=%b exp=1", f, spawn_ready); end
        end
    endtask

    task automatic test_midreset();
        logic [11:0] r;
        do_clear();
        spawn(11'd300, 11'd400);
        vsync_pulse();
        hcount_in = 11'd306; vcount_in = 11'd405; rgb_in = BG;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        $display("mid-frame reset: rgb_out=%h active_cnt=%0d rom_addr=%0d", rgb_out, active_cnt, rom_addr);
        n_checks++; if (rgb_out !== 12'h000) begin n_fail++; $display("FAIL mreset_rgb got=%h exp=000", rgb_out); end
        n_checks++; if (active_cnt !== 4'd0) begin n_fail++; $display("FAIL mreset_cnt got=%0d exp=0", active_cnt); end
        n_checks++; if (rom_addr !== 5'd0) begin n_fail++; $display("FAIL mreset_rom_addr got=%0d exp=0", rom_addr); end
        n_checks++; if (hcount_out !== 11'd0) begin n_fail++; $display("FAIL mreset_hcount got=%0d exp=0", hcount_out); end
        #2;
        rst_n = 1'b1;
        pix(11'd306, 11'd405, 1'b0, r);
        n_checks++; if (r !== BG) begin n_fail++; $display("FAIL mreset_pass got=%h exp=%h", r, BG); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
        rom[0] = 16'h0080;
        rom[5] = 16'h03C0;
        rom[6] = 16'hFFFF;
        test_reset();
        test_latency();
        test_basic();
        test_full();
        test_clear_spawn();
        test_midframe();
        test_commit_hazard();
        test_overlap();
        test_lifetime();
        test_midreset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "testbench did not finish");
    end

endmodule

// File: doc/headstone_ctl.md
Name: headstone_ctl

Overview:
- Manages up to SLOTS on-screen headstones and shares the single 16x32 headstone sprite ROM between them during the raster scan.
- Accepts spawn requests from game logic (pedestrian kill) through a valid/ready handshake.
- Commits new headstones only at frame start, so no tearing occurs.
- Sits in the VGA draw chain between the background/car drawing stage and the output, and drives the ROM line address.

Parameters:
- SLOTS, 4, number of headstone slots (1..8).
- SPR_W, 16, sprite width in pixels (equals the ROM word width).
- SPR_H, 32, sprite height in lines (equals the ROM depth).
- HS_RGB, 12'h888, colour for set sprite pixels.
- LIFE_FRAMES, 600, frames a headstone lives (used only with HEADSTONE_FADE_EN).

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcount_in  in  11  current pixel x
- vcount_in  in  11  current pixel y
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing in
- rgb_in  in  12  upstream pixel
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  timing delayed 2 cycles
- rgb_out  out  12  composited pixel
- spawn_valid  in  1  spawn request
- spawn_x  in  11  sprite left edge
- spawn_y  in  11  sprite top edge
- spawn_ready  out  1  free shadow slot exists and no clear is pending
- clear_all  in  1  remove all headstones
- rom_addr  out  5  sprite line to the ROM
- rom_data  in  16  ROM line, combinational; bit 15 is the leftmost pixel
- active_cnt  out  4  committed slots in use

Behaviour:
- Reset values:
  - All outputs are 0; rgb_out = 0.
  - Shadow and active tables are all invalid.
  - spawn_ready = 1 once reset deasserts.
- Tables:
  - Each slot holds valid, x and y.
  - The shadow table takes spawns. The active table is used for drawing.
  - On the vsync_in rising edge (registered edge detect), the active table is loaded from the shadow table in one cycle.
- Spawn:
  - Accepted on a cycle with spawn_valid & spawn_ready.
  - Written into the lowest-index invalid shadow slot.
  - spawn_ready is combinational from the shadow valid bits and clear_all: 0 when all shadow slots are valid or clear_all = 1.
  - spawn_x/spawn_y are stored unclipped.
- Clear:
  - clear_all invalidates all shadow slots in that cycle; clear wins over a simultaneous spawn.
  - The active table clears at the next vsync edge (the normal commit).
- Match, stage 1:
  - Slot i hits when active valid, hcount_in - x < SPR_W and vcount_in - y < SPR_H.
  - Comparisons are unsigned 11-bit, with subtraction and wrap, so off-screen coordinates never hit.
  - The lowest hit index wins.
  - rom_addr = (vcount_in - y_win)[4:0], driven combinationally; 0 when there is no hit.
  - Registered: hit, column = (hcount_in - x_win)[3:0], and rom_data latched in the same cycle.
- Stage 2:
  - pixel = rom_data_q[15 - col_q].
  - rgb_out = HS_RGB if hit_q & pixel & ~blank; otherwise rgb_d2.
  - Blanking forces pass-through of rgb.
- Latency: exactly 2 pclk from the inputs to all *_out; timing signals pass through identical 2-stage delays.
- Commit hazard: the vsync edge can coincide with a spawn. The spawn write lands in shadow after the copy, so that headstone appears on the following frame.
- active_cnt: population count of active valid bits, registered, updated on commit.
- Reset mid-frame: everything returns to reset values immediately; outputs are blank pass-through only after the pipeline refills (2 cycles).

Optional Feature:
- Macro: HEADSTONE_FADE_EN.
- Defined:
  - Each active slot has a 10-bit frame counter, loaded with LIFE_FRAMES when its spawn is committed.
  - The counter decrements at each vsync edge.
  - On reaching 0, both the active and shadow valid bits for that slot clear, freeing it.
  - A spawn committed into a slot reloads its counter.
- Undefined: no counters exist; slots persist until clear_all or reset.

Decomposition:
- Package headstone_pkg holds:
  - SPR_W, SPR_H, HS_RGB
  - SLOT_IDX_W = $clog2(SLOTS)
  - a slot record typedef {valid, x[10:0], y[10:0]}
  - the pipeline latency constant HS_LAT = 2
- One sub-module, headstone_slot_match: per-slot range compare producing hit, row[4:0] and col[3:0]. It is instantiated SLOTS times, with a priority encoder in the top.

Test Plan:
- Spawn (100,200), then vsync edge → rom_addr = 5 at (hcount 105, vcount 205); rgb_out = 12'h888 at hcount 106/107/108/109 (ROM row 5 = cols 6..9), 2 cycles later; col 5 passes rgb_in.
- Four spawns → spawn_ready = 0; a fifth spawn_valid is held and not accepted; active_cnt = 4 after vsync.
- Spawn mid-frame at (0,0) while scanning line 10 → no draw this frame; drawn next frame; row 6 fully set (16 pixels).
- Overlapping slots 0 at (50,50) and 1 at (52,50) → rom_addr taken from slot 0; pixel at col 8 of slot 0 (hcount 58) drawn.
- clear_all together with spawn_valid → spawn not accepted; after the next vsync active_cnt = 0; rgb_out == rgb_in everywhere.
- HEADSTONE_FADE_EN with LIFE_FRAMES = 3 → headstone drawn for frames 1–3, gone in frame 4; spawn_ready stays 1.
